// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-back path.
//   XLEN / NREG / AW : data width, architectural register count, register address width
//   wb_req_e         : requester identity used by the write-port arbiter
//   wb_req_t         : one write request (destination register + data)
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } wb_req_e;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: bundles the write-back scheduler's bus signals.
//   ALU result path : alu_valid/alu_ready/alu_rd/alu_data
//   load result path: mem_valid/mem_ready/mem_rd/mem_data
//   decode          : iss_valid/iss_ready/iss_rd, rs1/rs2, hazard
//   file write port : we3/a3/wd3, plus the busy scoreboard vector
//   master = producer/decode/file side, slave = the scheduler.
interface regfile_wb_scheduler_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [AW-1:0]     mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [AW-1:0]     iss_rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic              hazard;
  logic              we3;
  logic [AW-1:0]     a3;
  logic [XLEN-1:0]   wd3;
  logic [NREG-1:0]   busy;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  alu_ready, mem_ready, iss_ready, hazard,
    input  we3, a3, wd3, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output alu_ready, mem_ready, iss_ready, hazard,
    output we3, a3, wd3, busy
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter, at most one grant per cycle.
//   clk, rst : clock and synchronous active-high reset
//   req[1:0] : requests (bit 0 = ALU, bit 1 = MEM)
//   gnt[1:0] : one-hot grant, combinational; forced to 0 while rst is high
// The pointer remembers the last granted requester; on contention the other
// one wins. Reset leaves it at MEM so the ALU wins the first contested cycle.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_req_e last_q;
  wb_req_e last_d;

  always_ff @(posedge clk) begin
    if (rst) last_q <= REQ_MEM;
    else     last_q <= last_d;
  end

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
      if (gnt[0])      last_d = REQ_ALU;
      else if (gnt[1]) last_d = REQ_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates the register file's single write port
// between the ALU and load result paths and tracks outstanding writes.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of regfile_wb_scheduler_if (handshakes, decode
//              hazard/issue checks, registered we3/a3/wd3, busy vector)
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  regfile_wb_scheduler_if.slave  bus
);

  logic [1:0]      gnt;
  wb_req_t         win;
  logic            we_q;
  logic [AW-1:0]   a3_q;
  logic [XLEN-1:0] wd_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            iss_ok;
  logic            iss_fire;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.mem_valid, bus.alu_valid}),
    .gnt (gnt)
  );

  always_comb begin
    win.rd   = bus.alu_rd;
    win.data = bus.alu_data;
    if (gnt[1]) begin
      win.rd   = bus.mem_rd;
      win.data = bus.mem_data;
    end
  end

  // A grant to x0 still completes the handshake but never enables the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
    end else if (|gnt) begin
      we_q <= (win.rd != '0);
      a3_q <= win.rd;
      wd_q <= win.data;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign iss_ok   = !rst && (!busy_q[bus.iss_rd] || (bus.iss_rd == '0));
  assign iss_fire = bus.iss_valid && iss_ok;

  // Clear first, then set, so a same-edge collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[a3_q] = 1'b0;
    if (iss_fire && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];
  assign bus.iss_ready = iss_ok;
  assign bus.hazard    = ((bus.rs1 != '0) && busy_q[bus.rs1]) ||
                         ((bus.rs2 != '0) && busy_q[bus.rs2]);
  // Masked during reset so a write granted just before reset never commits.
  assign bus.we3       = we_q && !rst;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd_q;
  assign bus.busy      = busy_q;

endmodule
